pc_fetch_unit: RTL and testbench



---
 rtl/rv_core_pkg.sv | 17 +
 rtl/pc_fetch_unit_if.sv | 25 ++
 rtl/pc_next_sel.sv | 70 +++++++
 rtl/pc_fetch_unit.sv | 88 ++++++++
 tb/tb_pc_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_core_pkg.sv
// Shared core definitions: fetch FSM state encoding and default PC-unit geometry.
package rv_core_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam int          DEF_XLEN         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          INC_BYTES        = 4;
  localparam int          DEF_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch request channel between the PC unit (master) and instruction memory (slave).
interface pc_fetch_unit_if
  import rv_core_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
);
  logic [XLEN-1:0] o_pc;
  logic            o_fetch_valid;
  logic            i_fetch_ready;
  logic            o_fetch_kill;

  modport master (
    output o_pc,
    output o_fetch_valid,
    output o_fetch_kill,
    input  i_fetch_ready
  );

  modport slave (
    input  o_pc,
    input  o_fetch_valid,
    input  o_fetch_kill,
    output i_fetch_ready
  );
endinterface

// File: rtl/pc_next_sel.sv
// Priority mux for the fetch unit: picks next PC, next EPC, next state and the
// kill/misaligned pulse enables from the current state and this cycle's events.
module pc_next_sel
  import rv_core_pkg::*;
#(
  parameter int              XLEN        = DEF_XLEN,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR),
  parameter int              INC         = INC_BYTES,
  parameter int              ALIGN_BITS  = DEF_ALIGN_BITS
) (
  input  state_t          state,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic            pc_write,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap,
  input  logic            trap_ret,
  output state_t          state_next,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] epc_next,
  output logic            kill_next,
  output logic            misaligned_next
);

  localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

  logic target_misaligned;
  logic fault;

  assign target_misaligned = redirect_valid && (redirect_pc[ALIGN_BITS-1:0] != '0);
  assign fault             = trap || target_misaligned;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    epc_next        = epc;
    kill_next       = 1'b0;
    misaligned_next = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN, TRAP: begin
        if (fault) begin
          // A fault while already in the handler cannot be recovered: park in HALT
          if (state == TRAP) begin
            state_next = HALT;
          end else begin
            epc_next        = pc;
            pc_next         = TRAP_VECTOR;
            state_next      = TRAP;
            kill_next       = 1'b1;
            misaligned_next = !trap;
          end
        end else if (redirect_valid) begin
          pc_next   = redirect_pc;
          kill_next = 1'b1;
        end else if (trap_ret && (state == TRAP)) begin
          pc_next    = epc;
          state_next = RUN;
          kill_next  = 1'b1;
        end else if (fetch_ready && pc_write) begin
          pc_next = pc + INC_V;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch request generator: holds PC, EPC and the BOOT/RUN/TRAP/HALT
// state, and drives the fetch channel toward instruction memory.
module pc_fetch_unit
  import rv_core_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              INC          = INC_BYTES,
  parameter int              ALIGN_BITS   = DEF_ALIGN_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  pc_fetch_unit_if.master        fetch,
  input  logic                   i_PCWrite,
  input  logic                   i_redirect_valid,
  input  logic [XLEN-1:0]        i_redirect_pc,
  input  logic                   i_trap,
  input  logic                   i_trap_ret,
  output logic [XLEN-1:0]        o_epc,
  output logic                   o_misaligned,
  output logic                   o_halted
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            kill_q, kill_d;
  logic            mis_q, mis_d;
  logic            fetch_valid;
  logic            halted;

  pc_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INC         (INC),
    .ALIGN_BITS  (ALIGN_BITS)
  ) u_sel (
    .state           (state_q),
    .pc              (pc_q),
    .epc             (epc_q),
    .pc_write        (i_PCWrite),
    .fetch_ready     (fetch.i_fetch_ready),
    .redirect_valid  (i_redirect_valid),
    .redirect_pc     (i_redirect_pc),
    .trap            (i_trap),
    .trap_ret        (i_trap_ret),
    .state_next      (state_d),
    .pc_next         (pc_d),
    .epc_next        (epc_d),
    .kill_next       (kill_d),
    .misaligned_next (mis_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      kill_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      kill_q  <= kill_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    fetch_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      RUN, TRAP: fetch_valid = 1'b1;
      HALT:      halted      = 1'b1;
      default:   ;
    endcase
  end

  assign fetch.o_pc          = pc_q;
  assign fetch.o_fetch_valid = fetch_valid;
  assign fetch.o_fetch_kill  = kill_q;
  assign o_epc               = epc_q;
  assign o_misaligned        = mis_q;
  assign o_halted            = halted;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcw, rv, trap, tret;
  logic [31:0] rpc;
  logic [31:0] epc_w;
  logic        mis_w, halted_w;

  logic        reset8, pcw8, rv8;
  logic [7:0]  rpc8;
  logic [7:0]  epc8;
  logic        mis8, halted8;

  int n_run  = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_boot, m_handler, m_halt, m_kill, m_mis;

  pc_fetch_unit_if #(.XLEN(32)) fif ();
  pc_fetch_unit_if #(.XLEN(8))  fif8 ();

  pc_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .fetch            (fif),
    .i_PCWrite        (pcw),
    .i_redirect_valid (rv),
    .i_redirect_pc    (rpc),
    .i_trap           (trap),
    .i_trap_ret       (tret),
    .o_epc            (epc_w),
    .o_misaligned     (mis_w),
    .o_halted         (halted_w)
  );

  pc_fetch_unit #(
    .XLEN         (8),
    .RESET_VECTOR (8'h00),
    .TRAP_VECTOR  (8'h80),
    .INC          (4),
    .ALIGN_BITS   (2)
  ) dut8 (
    .clk              (clk),
    .reset            (reset8),
    .fetch            (fif8),
    .i_PCWrite        (pcw8),
    .i_redirect_valid (rv8),
    .i_redirect_pc    (rpc8),
    .i_trap           (1'b0),
    .i_trap_ret       (1'b0),
    .o_epc            (epc8),
    .o_misaligned     (mis8),
    .o_halted         (halted8)
  );

  always #5 clk = ~clk;

  function automatic logic [67:0] observe();
    return {fif.o_pc, epc_w, fif.o_fetch_valid, fif.o_fetch_kill, mis_w, halted_w};
  endfunction

  function automatic logic [67:0] expected();
    return {m_pc, m_epc, !m_boot && !m_halt, m_kill, m_mis, m_halt};
  endfunction

  // Reference model: applies this edge's inputs to the architectural view.
  task automatic model_update();
    logic bad;
    m_kill = 1'b0;
    m_mis  = 1'b0;
    if (reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_boot = 1'b1; m_handler = 1'b0; m_halt = 1'b0;
    end else if (m_halt) begin
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      bad = rv && (rpc % 4 != 0);
      if (trap || bad) begin
        if (m_handler) m_halt = 1'b1;
        else begin
          m_epc = m_pc; m_pc = 32'h100; m_handler = 1'b1; m_kill = 1'b1; m_mis = !trap;
        end
      end else if (rv) begin
        m_pc = rpc; m_kill = 1'b1;
      end else if (tret && m_handler) begin
        m_pc = m_epc; m_handler = 1'b0; m_kill = 1'b1;
      end else if (fif.i_fetch_ready && pcw) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [67:0] o;
    reset = 1'b1;
    step();
    o = observe();
    if (o !== {32'h0, 32'h0, 4'b0000}) begin
      n_fail++; $display("FAIL reset_state got %h want %h", o, {32'h0, 32'h0, 4'b0000});
    end
    n_run++;
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [67:0] o;
    fif.i_fetch_ready = 1'b1; pcw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      o = observe();
      if (o !== {32'(i * 4), 32'h0, 4'b1000}) begin
        n_fail++; $display("FAIL seq_pc%0d got %h want %h", i, o, {32'(i * 4), 32'h0, 4'b1000});
      end
      n_run++;
    end
  endtask

  task automatic test_stall();
    logic [67:0] o;
    for (int i = 0; i < 6; i++) begin
      fif.i_fetch_ready = (i >= 3);
      pcw               = (i == 5);
      step();
      o = observe();
      if (o !== {(i == 5) ? 32'hC : 32'h8, 32'h0, 4'b1000}) begin
        n_fail++; $display("FAIL stall_%0d got %h want pc %h", i, o, (i == 5) ? 32'hC : 32'h8);
      end
      n_run++;
    end
  endtask

  task automatic test_redirect();
    logic [67:0] o;
    fif.i_fetch_ready = 1'b0; pcw = 1'b0; rv = 1'b1; rpc = 32'h40;
    step();
    o = observe();
    if (o !== {32'h40, 32'h0, 4'b1100}) begin
      n_fail++; $display("FAIL redirect_take got %h want %h", o, {32'h40, 32'h0, 4'b1100});
    end
    n_run++;
    rv = 1'b0;
    step();
    o = observe();
    if (o !== {32'h40, 32'h0, 4'b1000}) begin
      n_fail++; $display("FAIL redirect_kill_once got %h want %h", o, {32'h40, 32'h0, 4'b1000});
    end
    n_run++;
  endtask

  task automatic test_misaligned();
    logic [67:0] o;
    rv = 1'b1; rpc = 32'h42;
    step();
    o = observe();
    if (o !== {32'h100, 32'h40, 4'b1110}) begin
      n_fail++; $display("FAIL misaligned got %h want %h", o, {32'h100, 32'h40, 4'b1110});
    end
    n_run++;
    rv = 1'b0; tret = 1'b1;
    step();
    tret = 1'b0; rv = 1'b1; rpc = 32'h20;
    step();
    o = observe();
    if (o !== {32'h20, 32'h40, 4'b1100}) begin
      n_fail++; $display("FAIL ret_then_redirect got %h want %h", o, {32'h20, 32'h40, 4'b1100});
    end
    n_run++;
    rv = 1'b0;
  endtask

  task automatic test_trap();
    logic [67:0] o;
    trap = 1'b1;
    step();
    o = observe();
    if (o !== {32'h100, 32'h20, 4'b1100}) begin
      n_fail++; $display("FAIL trap_entry got %h want %h", o, {32'h100, 32'h20, 4'b1100});
    end
    n_run++;
    trap = 1'b0; tret = 1'b1;
    step();
    o = observe();
    if (o !== {32'h20, 32'h20, 4'b1100}) begin
      n_fail++; $display("FAIL trap_ret got %h want %h", o, {32'h20, 32'h20, 4'b1100});
    end
    n_run++;
    step();
    o = observe();
    if (o !== {32'h20, 32'h20, 4'b1000}) begin
      n_fail++; $display("FAIL trap_ret_in_run got %h want %h", o, {32'h20, 32'h20, 4'b1000});
    end
    n_run++;
    tret = 1'b0;
  endtask

  task automatic test_double_fault();
    logic [67:0] o;
    trap = 1'b1;
    step();
    o = observe();
    if (o !== {32'h100, 32'h20, 4'b1100}) begin
      n_fail++; $display("FAIL df_first got %h want %h", o, {32'h100, 32'h20, 4'b1100});
    end
    n_run++;
    step();
    o = observe();
    if (o !== {32'h100, 32'h20, 4'b0001}) begin
      n_fail++; $display("FAIL df_halt got %h want %h", o, {32'h100, 32'h20, 4'b0001});
    end
    n_run++;
    trap = 1'b0; fif.i_fetch_ready = 1'b1; pcw = 1'b1;
    step();
    o = observe();
    if (o !== {32'h100, 32'h20, 4'b0001}) begin
      n_fail++; $display("FAIL df_stay got %h want %h", o, {32'h100, 32'h20, 4'b0001});
    end
    n_run++;
  endtask

  task automatic test_reset_halt();
    logic [67:0] o;
    reset = 1'b1;
    step();
    o = observe();
    if (o !== {32'h0, 32'h0, 4'b0000}) begin
      n_fail++; $display("FAIL halt_reset got %h want %h", o, {32'h0, 32'h0, 4'b0000});
    end
    n_run++;
    reset = 1'b0;
    step();
    o = observe();
    if (o !== {32'h0, 32'h0, 4'b1000}) begin
      n_fail++; $display("FAIL halt_reboot got %h want %h", o, {32'h0, 32'h0, 4'b1000});
    end
    n_run++;
  endtask

  task automatic test_simultaneous();
    logic [67:0] o;
    trap = 1'b1; rv = 1'b1; rpc = 32'h42;
    step();
    o = observe();
    if (o !== {32'h100, 32'h0, 4'b1100}) begin
      n_fail++; $display("FAIL sim_trap_redirect got %h want %h", o, {32'h100, 32'h0, 4'b1100});
    end
    n_run++;
    trap = 1'b0; rpc = 32'h80; tret = 1'b1;
    step();
    o = observe();
    if (o !== {32'h80, 32'h0, 4'b1100}) begin
      n_fail++; $display("FAIL sim_ret_redirect got %h want %h", o, {32'h80, 32'h0, 4'b1100});
    end
    n_run++;
    rv = 1'b0;
    step();
    o = observe();
    if (o !== {32'h0, 32'h0, 4'b1100}) begin
      n_fail++; $display("FAIL sim_still_trap got %h want %h", o, {32'h0, 32'h0, 4'b1100});
    end
    n_run++;
    tret = 1'b0;
  endtask

  task automatic test_random();
    logic [67:0] o, e;
    reset = 1'b1;
    step();
    for (int i = 0; i < 600; i++) begin
      reset             = ($urandom_range(0, 63) == 0);
      trap              = ($urandom_range(0, 15) == 0);
      tret              = ($urandom_range(0, 5) == 0);
      rv                = ($urandom_range(0, 4) == 0);
      rpc               = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) rpc = rpc & 32'hFFFF_FFFC;
      fif.i_fetch_ready = ($urandom_range(0, 3) != 0);
      pcw               = ($urandom_range(0, 3) != 0);
      step();
      o = observe();
      e = expected();
      if (o !== e) begin
        n_fail++; $display("FAIL random_%0d got %h want %h", i, o, e);
      end
      n_run++;
    end
    reset = 1'b0; trap = 1'b0; tret = 1'b0; rv = 1'b0;
  endtask

  task automatic test_wrap();
    reset8 = 1'b1;
    step();
    reset8 = 1'b0; fif8.i_fetch_ready = 1'b1; pcw8 = 1'b1;
    step();
    rv8 = 1'b1; rpc8 = 8'hFC;
    step();
    if (fif8.o_pc !== 8'hFC) begin
      n_fail++; $display("FAIL wrap_load got %h want fc", fif8.o_pc);
    end
    n_run++;
    rv8 = 1'b0;
    step();
    if (fif8.o_pc !== 8'h00 || fif8.o_fetch_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_zero got pc %h valid %b want pc 00 valid 1",
                         fif8.o_pc, fif8.o_fetch_valid);
    end
    n_run++;
  endtask

  initial begin
    reset = 1'b1; pcw = 1'b0; rv = 1'b0; trap = 1'b0; tret = 1'b0; rpc = 32'h0;
    fif.i_fetch_ready = 1'b0;
    reset8 = 1'b1; pcw8 = 1'b0; rv8 = 1'b0; rpc8 = 8'h0;
    fif8.i_fetch_ready = 1'b0;
    m_pc = 32'h0; m_epc = 32'h0; m_boot = 1'b1; m_handler = 1'b0;
    m_halt = 1'b0; m_kill = 1'b0; m_mis = 1'b0;
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misaligned();
    test_trap();
    test_double_fault();
    test_reset_halt();
    test_simultaneous();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
